// File: rtl/FetchUnitTypes.sv
// Shared types for the approximate-BCC BTB update path: queued entry layout
// and the bank mapping used by both the update queue and the BTB.
package FetchUnitTypes;

    localparam int AXBTB_PC_WIDTH  = 32;
    localparam int AXBTB_BANK_BITS = 1;

    typedef struct packed {
        logic [AXBTB_PC_WIDTH-1:0] brAddr;
        logic [AXBTB_PC_WIDTH-1:0] nextAddr;
        logic                      isCondBr;
    } AXBTBUpdateEntry;

    function automatic logic [AXBTB_BANK_BITS-1:0] ToAXBTB_Bank(
        input logic [AXBTB_PC_WIDTH-1:0] addr
    );
        return addr[AXBTB_BANK_BITS+1:2];
    endfunction

endpackage

// File: rtl/ax_btb_bank_drain_select.sv
// Picks the longest in-order run of head entries whose BTB banks are pairwise
// distinct; the first conflict ends the run so writes never reorder.
module ax_btb_bank_drain_select
    import FetchUnitTypes::*;
#(
    parameter int LANES = 2
) (
    input  logic [AXBTB_BANK_BITS-1:0] bank_i    [LANES],
    input  logic [LANES-1:0]           valid_i,
    output logic [LANES-1:0]           sel_o,
    output logic [$clog2(LANES+1)-1:0] pop_cnt_o
);

    localparam int NW = $clog2(LANES + 1);

    logic stop;

    always_comb begin
        sel_o = '0;
        stop  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (!valid_i[k]) stop = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (bank_i[j] == bank_i[k]) stop = 1'b1;
            end
            if (!stop) sel_o[k] = 1'b1;
        end
    end

    always_comb begin
        pop_cnt_o = '0;
        for (int k = 0; k < LANES; k++) begin
            if (sel_o[k]) pop_cnt_o = pop_cnt_o + NW'(1);
        end
    end

endmodule

// File: rtl/ax_btb_update_queue.sv
// In-order staging FIFO between branch-result lanes and the AP-BCC BTB write
// ports: filters, dedups, buffers, and drains bank-conflict-free groups.
module ax_btb_update_queue
    import FetchUnitTypes::*;
#(
    parameter int LANES     = 2,
    parameter int DEPTH     = 8,
    parameter int PC_WIDTH  = AXBTB_PC_WIDTH,
    parameter int BANK_BITS = AXBTB_BANK_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   resValid    [LANES],
    input  logic                   resTaken    [LANES],
    input  logic                   resIsApBCC  [LANES],
    input  logic                   resIsCondBr [LANES],
    input  logic [PC_WIDTH-1:0]    resBrAddr   [LANES],
    input  logic [PC_WIDTH-1:0]    resNextAddr [LANES],
    input  logic                   hold,
    output logic                   wValid      [LANES],
    output logic [PC_WIDTH-1:0]    wAddr       [LANES],
    output logic [PC_WIDTH-1:0]    wTarget     [LANES],
    output logic                   wIsCondBr   [LANES],
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [15:0]            dropCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = $clog2(LANES + 1);

    // Entry layout and bank mapping come from the shared package.
    if (PC_WIDTH != AXBTB_PC_WIDTH || BANK_BITS != AXBTB_BANK_BITS) begin : g_cfg_check
        $error("PC_WIDTH/BANK_BITS must match FetchUnitTypes");
    end

    AXBTBUpdateEntry            mem_q [DEPTH];
    logic [PW-1:0]              head_q, tail_q;
    logic [CW-1:0]              count_q, count_d;
    logic [15:0]                drop_q, drop_d;

    logic [LANES-1:0]           elig, survive, wr_en;
    logic [PW-1:0]              wr_idx [LANES];
    logic [CW-1:0]              free, push_n, drop_n;

    AXBTBUpdateEntry            head_ent  [LANES];
    logic [AXBTB_BANK_BITS-1:0] head_bank [LANES];
    logic [LANES-1:0]           head_vld, sel;
    logic [NW-1:0]              pop_n;
    logic [16:0]                drop_sum;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            elig[i] = resValid[i] & resTaken[i] & resIsApBCC[i];
        end
    end

    // Same-PC results in one cycle: only the youngest lane survives.
    always_comb begin
        survive = elig;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (elig[j] && resBrAddr[j] == resBrAddr[i]) survive[i] = 1'b0;
            end
        end
    end

    // Space is judged on start-of-cycle occupancy; same-cycle pops do not help.
    always_comb begin
        free   = CW'(DEPTH) - count_q;
        push_n = '0;
        drop_n = '0;
        wr_en  = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_idx[i] = tail_q + push_n[PW-1:0];
            if (survive[i]) begin
                if (push_n < free) begin
                    wr_en[i] = 1'b1;
                    push_n   = push_n + CW'(1);
                end else begin
                    drop_n   = drop_n + CW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            head_ent[k]  = mem_q[head_q + PW'(k)];
            head_bank[k] = ToAXBTB_Bank(head_ent[k].brAddr);
            head_vld[k]  = !hold && (CW'(k) < count_q);
        end
    end

    ax_btb_bank_drain_select #(
        .LANES(LANES)
    ) u_drain_sel (
        .bank_i   (head_bank),
        .valid_i  (head_vld),
        .sel_o    (sel),
        .pop_cnt_o(pop_n)
    );

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            wValid[k]    = sel[k];
            wAddr[k]     = sel[k] ? head_ent[k].brAddr   : '0;
            wTarget[k]   = sel[k] ? head_ent[k].nextAddr : '0;
            wIsCondBr[k] = sel[k] & head_ent[k].isCondBr;
        end
    end

    always_comb begin
        count_d  = count_q + push_n - CW'(pop_n);
        drop_sum = {1'b0, drop_q} + 17'(drop_n);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_q + PW'(pop_n);
            tail_q  <= tail_q + push_n[PW-1:0];
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_idx[i]] <= '{brAddr:   resBrAddr[i],
                                      nextAddr: resNextAddr[i],
                                      isCondBr: resIsCondBr[i]};
            end
        end
    end

    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign dropCount = drop_q;

endmodule

// File: tb/tb_ax_btb_update_queue.sv
// Directed bench for ax_btb_update_queue: expected writes are queued as stimulus
// is issued and a negedge monitor checks every write port against that queue.
module tb_ax_btb_update_queue;

    localparam int LANES = 2;
    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        resValid    [LANES];
    logic        resTaken    [LANES];
    logic        resIsApBCC  [LANES];
    logic        resIsCondBr [LANES];
    logic [31:0] resBrAddr   [LANES];
    logic [31:0] resNextAddr [LANES];
    logic        hold;
    logic        wValid      [LANES];
    logic [31:0] wAddr       [LANES];
    logic [31:0] wTarget     [LANES];
    logic        wIsCondBr   [LANES];
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] dropCount;

    typedef struct {
        logic [31:0] a;
        logic [31:0] t;
        logic        c;
    } exp_t;

    exp_t sb [$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    ax_btb_update_queue #(
        .LANES(LANES), .DEPTH(DEPTH), .PC_WIDTH(32), .BANK_BITS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .resValid(resValid), .resTaken(resTaken), .resIsApBCC(resIsApBCC),
        .resIsCondBr(resIsCondBr), .resBrAddr(resBrAddr), .resNextAddr(resNextAddr),
        .hold(hold),
        .wValid(wValid), .wAddr(wAddr), .wTarget(wTarget), .wIsCondBr(wIsCondBr),
        .count(count), .full(full), .empty(empty), .dropCount(dropCount)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic clear_lanes();
        for (int l = 0; l < LANES; l++) begin
            resValid[l] = 1'b0; resTaken[l] = 1'b0; resIsApBCC[l] = 1'b0;
            resIsCondBr[l] = 1'b0; resBrAddr[l] = '0; resNextAddr[l] = '0;
        end
    endtask

    task automatic set_lane(input int l, input logic v, input logic t, input logic ap,
                            input logic c, input logic [31:0] a, input logic [31:0] n);
        resValid[l] = v; resTaken[l] = t; resIsApBCC[l] = ap;
        resIsCondBr[l] = c; resBrAddr[l] = a; resNextAddr[l] = n;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] t, input logic c);
        exp_t x;
        x.a = a; x.t = t; x.c = c;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_lanes();
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Monitor: every asserted port must match the next expected write in order.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < LANES; k++) begin
                n_cmp++;
                if (wValid[k]) begin
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_write port%0d: got addr=%0h, expected no write",
                                 k, wAddr[k]);
                    end else begin
                        e = sb.pop_front();
                        if (wAddr[k] !== e.a || wTarget[k] !== e.t || wIsCondBr[k] !== e.c) begin
                            n_bad++;
                            $display("FAIL write_port%0d: got addr=%0h tgt=%0h cond=%0b, expected addr=%0h tgt=%0h cond=%0b",
                                     k, wAddr[k], wTarget[k], wIsCondBr[k], e.a, e.t, e.c);
                        end
                    end
                end else if (wAddr[k] !== '0 || wTarget[k] !== '0 || wIsCondBr[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL idle_port%0d: got addr=%0h tgt=%0h cond=%0b, expected zeros",
                             k, wAddr[k], wTarget[k], wIsCondBr[k]);
                end
            end
            if (wValid[0] && wValid[1]) begin
                n_cmp++;
                if (wAddr[0][2] === wAddr[1][2]) begin
                    n_bad++;
                    $display("FAIL bank_conflict: got banks %0b/%0b, expected distinct",
                             wAddr[0][2], wAddr[1][2]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b0;
        hold = 1'b0;
        clear_lanes();
        #1 rst = 1'b1;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_drop", 32'(dropCount), 32'd0);
        chk("rst_wvalid0", 32'(wValid[0]), 32'd0);
        chk("rst_wvalid1", 32'(wValid[1]), 32'd0);
        #1 rst = 1'b0;
        step();

        // Single eligible result
        set_lane(0, 1, 1, 1, 1, 32'h1000, 32'h2000);
        expect_wr(32'h1000, 32'h2000, 1'b1);
        step();
        chk("single_count1", 32'(count), 32'd1);
        chk("single_wvalid0", 32'(wValid[0]), 32'd1);
        chk("single_wvalid1", 32'(wValid[1]), 32'd0);
        chk("single_waddr0", wAddr[0], 32'h1000);
        chk("single_wtarget0", wTarget[0], 32'h2000);
        step();
        chk("single_count0", 32'(count), 32'd0);
        chk("single_empty", 32'(empty), 32'd1);

        // Same-cycle duplicate: younger lane wins, no drop
        set_lane(0, 1, 1, 1, 0, 32'h1004, 32'h2222);
        set_lane(1, 1, 1, 1, 1, 32'h1004, 32'h3000);
        expect_wr(32'h1004, 32'h3000, 1'b1);
        step();
        chk("dedup_count", 32'(count), 32'd1);
        chk("dedup_drop", 32'(dropCount), 32'd0);
        chk("dedup_wvalid1", 32'(wValid[1]), 32'd0);
        step();
        chk("dedup_empty", 32'(empty), 32'd1);

        // Filter: not taken / not AP-BCC / not valid
        set_lane(0, 1, 0, 1, 0, 32'h1100, 32'h5000);
        set_lane(1, 1, 1, 0, 0, 32'h1104, 32'h5004);
        step();
        chk("filter_count", 32'(count), 32'd0);
        set_lane(0, 0, 1, 1, 0, 32'h1200, 32'h5100);
        set_lane(1, 1, 1, 1, 0, 32'h1204, 32'h5104);
        expect_wr(32'h1204, 32'h5104, 1'b0);
        step();
        chk("filter_count1", 32'(count), 32'd1);
        step();
        chk("filter_empty", 32'(empty), 32'd1);

        // Same bank: one write per cycle, in order
        set_lane(0, 1, 1, 1, 0, 32'h1000, 32'hA000);
        set_lane(1, 1, 1, 1, 1, 32'h1008, 32'hA008);
        expect_wr(32'h1000, 32'hA000, 1'b0);
        expect_wr(32'h1008, 32'hA008, 1'b1);
        step();
        chk("samebank_count2", 32'(count), 32'd2);
        chk("samebank_c1_wvalid0", 32'(wValid[0]), 32'd1);
        chk("samebank_c1_wvalid1", 32'(wValid[1]), 32'd0);
        step();
        chk("samebank_count1", 32'(count), 32'd1);
        chk("samebank_c2_wvalid0", 32'(wValid[0]), 32'd1);
        chk("samebank_c2_wvalid1", 32'(wValid[1]), 32'd0);
        chk("samebank_c2_waddr0", wAddr[0], 32'h1008);
        step();
        chk("samebank_empty", 32'(empty), 32'd1);

        // Different banks: both ports in one cycle
        set_lane(0, 1, 1, 1, 0, 32'h2000, 32'hB000);
        set_lane(1, 1, 1, 1, 0, 32'h2004, 32'hB004);
        expect_wr(32'h2000, 32'hB000, 1'b0);
        expect_wr(32'h2004, 32'hB004, 1'b0);
        step();
        chk("altbank_count", 32'(count), 32'd2);
        chk("altbank_wvalid0", 32'(wValid[0]), 32'd1);
        chk("altbank_wvalid1", 32'(wValid[1]), 32'd1);
        chk("altbank_waddr1", wAddr[1], 32'h2004);
        step();
        chk("altbank_empty", 32'(count), 32'd0);

        // Hold: fill to full, then overflow drops
        hold = 1'b1;
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < LANES; l++) begin
                set_lane(l, 1, 1, 1, l[0], 32'h4000 + 32'(4 * (2 * c + l)), 32'h8000 + 32'(2 * c + l));
                expect_wr(32'h4000 + 32'(4 * (2 * c + l)), 32'h8000 + 32'(2 * c + l), l[0]);
            end
            step();
        end
        chk("hold_count8", 32'(count), 32'd8);
        chk("hold_full", 32'(full), 32'd1);
        chk("hold_wvalid0", 32'(wValid[0]), 32'd0);
        set_lane(0, 1, 1, 1, 0, 32'h5000, 32'h1);
        set_lane(1, 1, 1, 1, 0, 32'h5004, 32'h2);
        step();
        chk("hold_drop2", 32'(dropCount), 32'd2);
        chk("hold_count_still8", 32'(count), 32'd8);
        // Release hold while full and offering two more: pops do not make room
        hold = 1'b0;
        set_lane(0, 1, 1, 1, 0, 32'h6000, 32'h3);
        set_lane(1, 1, 1, 1, 0, 32'h6004, 32'h4);
        step();
        chk("fullpop_count6", 32'(count), 32'd6);
        chk("fullpop_drop4", 32'(dropCount), 32'd4);
        chk("fullpop_notfull", 32'(full), 32'd0);
        step();
        chk("drain_count4", 32'(count), 32'd4);
        step();
        chk("drain_count2", 32'(count), 32'd2);
        step();
        chk("drain_count0", 32'(count), 32'd0);

        // Pointer wrap: 20 alternating-bank pushes with concurrent drain
        for (int c = 0; c < 10; c++) begin
            set_lane(0, 1, 1, 1, 0, 32'h7000 + 32'(8 * c), 32'h9000 + 32'(8 * c));
            set_lane(1, 1, 1, 1, 1, 32'h7004 + 32'(8 * c), 32'h9004 + 32'(8 * c));
            expect_wr(32'h7000 + 32'(8 * c), 32'h9000 + 32'(8 * c), 1'b0);
            expect_wr(32'h7004 + 32'(8 * c), 32'h9004 + 32'(8 * c), 1'b1);
            step();
            chk("wrap_count", 32'(count), 32'd2);
        end
        step();
        chk("wrap_empty", 32'(count), 32'd0);

        // Async reset mid-drain with five entries queued
        hold = 1'b1;
        set_lane(0, 1, 1, 1, 0, 32'hB000, 32'h10);
        set_lane(1, 1, 1, 1, 0, 32'hB004, 32'h11);
        step();
        set_lane(0, 1, 1, 1, 0, 32'hB008, 32'h12);
        set_lane(1, 1, 1, 1, 0, 32'hB00C, 32'h13);
        step();
        set_lane(0, 1, 1, 1, 0, 32'hB010, 32'h14);
        step();
        chk("arst_pre_count5", 32'(count), 32'd5);
        hold = 1'b0;
        #1;
        chk("arst_pre_wvalid0", 32'(wValid[0]), 32'd1);
        chk("arst_pre_waddr0", wAddr[0], 32'hB000);
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_wvalid0", 32'(wValid[0]), 32'd0);
        chk("arst_wvalid1", 32'(wValid[1]), 32'd0);
        chk("arst_drop", 32'(dropCount), 32'd0);
        #1 rst = 1'b0;
        step();

        // Queue works again after reset
        set_lane(0, 1, 1, 1, 1, 32'hC000, 32'hD000);
        expect_wr(32'hC000, 32'hD000, 1'b1);
        step();
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_waddr0", wAddr[0], 32'hC000);
        step();
        chk("post_rst_empty", 32'(empty), 32'd1);
        step();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
